alu_seq_controller: RTL

Parametrised, registered successor to the single-cycle ALU decode stage. Decodes `alu_op`/`func` into a registered `alu_operation` and adds a multi-cycle unsigned multiply (MULTU) with HI/LO registers and MFHI/MFLO result selection. A valid/ready handshake lets the multicycle datapath controller stall while a multiply is in progress. Sits between the main control FSM and the ALU / register-file write-back mux.

---
 rtl/alu_seq_controller_pkg.sv | 64 ++++++
 rtl/alu_seq_controller_mult.sv | 50 +++++
 rtl/alu_seq_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_seq_controller_pkg.sv
// Shared codes and the instruction decoder for the ALU sequencing controller.
// ALU, func, instruction-class and write-back select encodings live here.
package alu_seq_controller_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_OFF = 3'b100;

  localparam logic [1:0] OP_MTYPE = 2'b00;
  localparam logic [1:0] OP_BTYPE = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_JTYPE = 2'b11;

  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_HI  = 2'b01;
  localparam logic [1:0] SEL_LO  = 2'b10;

  typedef struct packed {
    logic [2:0] alu_operation;
    logic [1:0] result_sel;
    logic       illegal;
    logic       is_mul;
  } decode_t;

  function automatic decode_t decode(input logic [1:0] alu_op, input logic [5:0] func);
    decode_t d;
    d.alu_operation = ALU_OFF;
    d.result_sel    = SEL_ALU;
    d.illegal       = 1'b0;
    d.is_mul        = 1'b0;
    case (alu_op)
      OP_MTYPE: d.alu_operation = ALU_ADD;
      OP_BTYPE: d.alu_operation = ALU_SUB;
      OP_JTYPE: d.alu_operation = ALU_OFF;
      default: begin
        case (func)
          FUNC_ADD:   d.alu_operation = ALU_ADD;
          FUNC_SUB:   d.alu_operation = ALU_SUB;
          FUNC_AND:   d.alu_operation = ALU_AND;
          FUNC_OR:    d.alu_operation = ALU_OR;
          FUNC_SLT:   d.alu_operation = ALU_SLT;
          FUNC_MFHI:  d.result_sel    = SEL_HI;
          FUNC_MFLO:  d.result_sel    = SEL_LO;
          FUNC_MULTU: d.is_mul        = 1'b1;
          default:    d.illegal       = 1'b1;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_seq_controller_mult.sv
// Iterative radix-2 shift-add unsigned multiplier, one multiplier bit per cycle.
// last_c_o/product_c_o expose the final step so the caller can capture the product on that edge.
module alu_seq_controller_mult #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_c_o,
  output logic [2*WIDTH-1:0] product_c_o
);
  import alu_seq_controller_pkg::*;

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [PROD_W-1:0] mcand_q, acc_q, sum_c;
  logic [WIDTH-1:0]  mplier_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              run_q;

  assign sum_c       = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_c_o    = run_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign product_c_o = sum_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= PROD_W'(a_i);
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= sum_c;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      if (last_c_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_controller.sv
// Registered ALU decode with a multi-cycle MULTU and HI/LO product registers.
// Requests are accepted only in IDLE; a multiply blocks acceptance until its DONE pulse.
module alu_seq_controller #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [2:0]       alu_operation,
  output logic [1:0]       result_sel,
  output logic             out_valid,
  output logic             illegal,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import alu_seq_controller_pkg::*;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_MUL  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  logic [1:0]         state_q, state_d;
  logic [2:0]         alu_operation_q, alu_operation_d;
  logic [1:0]         result_sel_q, result_sel_d;
  logic               out_valid_q, out_valid_d;
  logic               illegal_q, illegal_d;
  logic               ready_q, busy_q;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               mul_start_c, mul_last_c;
  logic [2*WIDTH-1:0] mul_product_c;
  decode_t            dec_c;

  assign dec_c = decode(alu_op, func);

  alu_seq_controller_mult #(.WIDTH(WIDTH)) u_mult (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (mul_start_c),
    .a_i         (op_a),
    .b_i         (op_b),
    .last_c_o    (mul_last_c),
    .product_c_o (mul_product_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      alu_operation_q <= ALU_OFF;
      result_sel_q    <= SEL_ALU;
      out_valid_q     <= 1'b0;
      illegal_q       <= 1'b0;
      ready_q         <= 1'b1;
      busy_q          <= 1'b0;
      hi_q            <= '0;
      lo_q            <= '0;
    end else begin
      state_q         <= state_d;
      alu_operation_q <= alu_operation_d;
      result_sel_q    <= result_sel_d;
      out_valid_q     <= out_valid_d;
      illegal_q       <= illegal_d;
      ready_q         <= (state_d == S_IDLE);
      busy_q          <= (state_d != S_IDLE);
      hi_q            <= hi_d;
      lo_q            <= lo_d;
    end
  end

  // Next state and registered-output updates; ready/busy track the next state.
  always_comb begin
    state_d         = state_q;
    alu_operation_d = alu_operation_q;
    result_sel_d    = result_sel_q;
    out_valid_d     = 1'b0;
    illegal_d       = 1'b0;
    hi_d            = hi_q;
    lo_d            = lo_q;
    mul_start_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (dec_c.is_mul) begin
            mul_start_c = 1'b1;
            state_d     = S_MUL;
          end else begin
            out_valid_d     = 1'b1;
            illegal_d       = dec_c.illegal;
            alu_operation_d = dec_c.alu_operation;
            result_sel_d    = dec_c.result_sel;
          end
        end
      end
      S_MUL: begin
        if (mul_last_c) begin
          hi_d            = mul_product_c[2*WIDTH-1:WIDTH];
          lo_d            = mul_product_c[WIDTH-1:0];
          out_valid_d     = 1'b1;
          alu_operation_d = ALU_OFF;
          result_sel_d    = SEL_ALU;
          state_d         = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ready         = ready_q;
  assign busy          = busy_q;
  assign alu_operation = alu_operation_q;
  assign result_sel    = result_sel_q;
  assign out_valid     = out_valid_q;
  assign illegal       = illegal_q;
  assign hi            = hi_q;
  assign lo            = lo_q;

endmodule
